note_frame_sequencer: RTL and testbench

// - Schedules per-frame FFT peak bins through the shared single-request note lookup engine.
// - Sits between the FFT peak picker and the transcription/display logic.
// - Buffers peak bins in a FIFO and issues one lookup at a time.
// - ORs the resulting note hits into a per-frame note mask.
// - Emits the mask after the entry flagged last in the frame has been resolved.

---
 rtl/note_frame_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_note_frame_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_frame_sequencer.sv
// note_frame_sequencer
//
// Purpose:
//   Queues FFT peak bins from the peak picker and feeds them one at a time
//   through the shared note lookup engine. Note hits returned by the engine
//   are ORed into a per-frame note mask. The mask is published once the
//   entry flagged as the last of its frame has been resolved.
//
// Ports:
//   clk_in, rst_in        clock and synchronous active-high reset
//   peak_bin/peak_last    peak entry from the peak picker
//   peak_valid/peak_ready handshake; a transfer happens when both are high
//   lk_bin                bin presented to the lookup engine, held per lookup
//   lk_start              single-cycle request pulse to the lookup engine
//   lk_done/lk_note       single-cycle result strobe and {hit, note index}
//   mask_out/mask_valid   last completed frame's mask and its update pulse
//   busy                  lookup in progress or peaks still queued
//   timeout_count         saturating count of lookup watchdog expiries
//
// Build option:
//   NOTE_SEQ_TIMEOUT_EN  when defined, a lookup that gets no answer within
//                        TIMEOUT_CYC cycles is resolved as a miss and counted
//                        in timeout_count. Otherwise the sequencer waits for
//                        lk_done indefinitely and timeout_count reads 0.

module note_frame_sequencer #(
  parameter int BIN_W       = 13,
  parameter int NUM_NOTES   = 22,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [BIN_W-1:0]     peak_bin,
  input  logic                 peak_last,
  input  logic                 peak_valid,
  output logic                 peak_ready,
  output logic [BIN_W-1:0]     lk_bin,
  output logic                 lk_start,
  input  logic                 lk_done,
  input  logic [5:0]           lk_note,
  output logic [NUM_NOTES-1:0] mask_out,
  output logic                 mask_valid,
  output logic                 busy,
  output logic [7:0]           timeout_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = BIN_W + 1;
  localparam logic [AW:0] FIFO_FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [5:0]  NOTE_LIMIT    = 6'(NUM_NOTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_EMIT
  } state_t;

  state_t state_q, state_d;

  // Peak FIFO: entries are {last, bin}
  logic [EW-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          fifo_full, fifo_empty, push, pop;
  logic [EW-1:0] fifo_head;

  // No bypass: a full FIFO refuses a push even when it pops the same cycle.
  assign fifo_full  = (count_q == FIFO_FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign push       = peak_valid && !fifo_full;
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  assign fifo_head  = fifo_mem_q[rd_ptr_q];

  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {peak_last, peak_bin};
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Lookup result decode
  logic                 note_hit;
  logic [NUM_NOTES-1:0] note_onehot;
  logic [NUM_NOTES-1:0] acc_next;
  logic                 expired;

  assign note_hit    = lk_done && lk_note[5] && ({1'b0, lk_note[4:0]} < NOTE_LIMIT);
  assign note_onehot = {{(NUM_NOTES-1){1'b0}}, 1'b1} << lk_note[4:0];

`ifdef NOTE_SEQ_TIMEOUT_EN
  localparam int WCW = $clog2(TIMEOUT_CYC + 1);

  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [7:0]     tmo_cnt_q, tmo_cnt_d;

  // Expiry fires on the TIMEOUT_CYC-th WAIT cycle with no answer.
  assign expired = (state_q == S_WAIT) && !lk_done &&
                   (wait_cnt_q == WCW'(TIMEOUT_CYC - 1));

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    if (state_q == S_ISSUE) begin
      wait_cnt_d = '0;
    end else if ((state_q == S_WAIT) && !lk_done && !expired) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
    if (expired && (tmo_cnt_q != 8'hFF)) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wait_cnt_q <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign timeout_count = tmo_cnt_q;
`else
  assign expired       = 1'b0;
  assign timeout_count = '0;
`endif

  // Sequencer FSM
  logic [BIN_W-1:0]     lk_bin_q, lk_bin_d;
  logic                 cur_last_q, cur_last_d;
  logic [NUM_NOTES-1:0] acc_q, acc_d;
  logic [NUM_NOTES-1:0] mask_out_q, mask_out_d;
  logic                 mask_valid_q, mask_valid_d;

  assign acc_next = acc_q | (note_hit ? note_onehot : '0);

  // The mask register is loaded on the edge that enters EMIT, so mask_out
  // and mask_valid are both presented during the EMIT cycle, one cycle after
  // the last entry's lk_done.
  always_comb begin
    state_d      = state_q;
    lk_bin_d     = lk_bin_q;
    cur_last_d   = cur_last_q;
    acc_d        = acc_q;
    mask_out_d   = mask_out_q;
    mask_valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          lk_bin_d   = fifo_head[BIN_W-1:0];
          cur_last_d = fifo_head[BIN_W];
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lk_done || expired) begin
          if (cur_last_q) begin
            mask_out_d   = acc_next;
            mask_valid_d = 1'b1;
            acc_d        = '0;
            state_d      = S_EMIT;
          end else begin
            acc_d   = acc_next;
            state_d = S_IDLE;
          end
        end
      end
      S_EMIT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      lk_bin_q     <= '0;
      cur_last_q   <= 1'b0;
      acc_q        <= '0;
      mask_out_q   <= '0;
      mask_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lk_bin_q     <= lk_bin_d;
      cur_last_q   <= cur_last_d;
      acc_q        <= acc_d;
      mask_out_q   <= mask_out_d;
      mask_valid_q <= mask_valid_d;
    end
  end

  assign peak_ready = !fifo_full;
  assign lk_bin     = lk_bin_q;
  assign lk_start   = (state_q == S_ISSUE);
  assign mask_out   = mask_out_q;
  assign mask_valid = mask_valid_q;
  assign busy       = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_note_frame_sequencer.sv
module tb_note_frame_sequencer;

  localparam int BIN_W     = 13;
  localparam int NUM_NOTES = 22;

  logic                 clk = 1'b0;
  logic                 rst_in;
  logic [BIN_W-1:0]     peak_bin;
  logic                 peak_last;
  logic                 peak_valid;
  logic                 peak_ready;
  logic [BIN_W-1:0]     lk_bin;
  logic                 lk_start;
  logic                 lk_done;
  logic [5:0]           lk_note;
  logic [NUM_NOTES-1:0] mask_out;
  logic                 mask_valid;
  logic                 busy;
  logic [7:0]           timeout_count;

  always #5 clk = ~clk;

  note_frame_sequencer #(
    .BIN_W      (BIN_W),
    .NUM_NOTES  (NUM_NOTES),
    .FIFO_DEPTH (8),
    .TIMEOUT_CYC(32)
  ) dut (
    .clk_in       (clk),
    .rst_in       (rst_in),
    .peak_bin     (peak_bin),
    .peak_last    (peak_last),
    .peak_valid   (peak_valid),
    .peak_ready   (peak_ready),
    .lk_bin       (lk_bin),
    .lk_start     (lk_start),
    .lk_done      (lk_done),
    .lk_note      (lk_note),
    .mask_out     (mask_out),
    .mask_valid   (mask_valid),
    .busy         (busy),
    .timeout_count(timeout_count)
  );

  typedef struct {
    logic [BIN_W-1:0]     bin;
    logic                 last;
    logic [5:0]           note;
    bit                   noans;
    logic [NUM_NOTES-1:0] exp_mask;
  } vec_t;

  typedef struct {
    logic [BIN_W-1:0] bin;
    logic [5:0]       note;
    bit               noans;
  } lk_t;

  lk_t                  lk_q[$];
  logic [NUM_NOTES-1:0] mask_q[$];

  int n_vec    = 0;
  int n_err    = 0;
  int lk_cnt   = 0;
  int mask_cnt = 0;
  bit eng_stall = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Lookup engine model: answers each request in order after 1..3 cycles.
  initial begin : engine
    lk_t e;
    lk_done = 1'b0;
    lk_note = '0;
    forever begin
      @(negedge clk);
      lk_done = 1'b0;
      lk_note = '0;
      if (lk_start === 1'b1 && rst_in === 1'b0) begin
        lk_cnt++;
        if (lk_q.size() == 0) begin
          check("lk_start_unexpected", 32'd1, 32'd0);
        end else begin
          e = lk_q.pop_front();
          check("lk_bin", 32'(lk_bin), 32'(e.bin));
          while (eng_stall) @(negedge clk);
          repeat ($urandom_range(1, 3)) @(negedge clk);
          if (!e.noans) begin
            lk_done = 1'b1;
            lk_note = e.note;
          end
        end
      end
    end
  end

  // Mask scoreboard
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (mask_valid === 1'b1) begin
        mask_cnt++;
        if (mask_q.size() == 0) begin
          check("mask_valid_unexpected", 32'd1, 32'd0);
        end else begin
          check("mask_out", 32'(mask_out), 32'(mask_q.pop_front()));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, n_vec=%0d", n_vec);
    $fatal(1, "watchdog expired");
  end

  task automatic push_peak(input logic [BIN_W-1:0] bin, input logic last,
                           input logic [5:0] note, input bit noans,
                           input logic [NUM_NOTES-1:0] exp_mask);
    int  guard;
    lk_t e;
    guard      = 0;
    peak_bin   = bin;
    peak_last  = last;
    peak_valid = 1'b1;
    while (!peak_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (!peak_ready) begin
      check("push_ready_timeout", 32'd0, 32'd1);
      peak_valid = 1'b0;
      return;
    end
    e.bin   = bin;
    e.note  = note;
    e.noans = noans;
    lk_q.push_back(e);
    if (last) mask_q.push_back(exp_mask);
    @(negedge clk);
    peak_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while ((busy || mask_q.size() != 0 || lk_q.size() != 0) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check(name, 32'(guard < 2000), 32'd1);
  endtask

  task automatic do_reset();
    rst_in     = 1'b1;
    peak_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_in = 1'b0;
    lk_q.delete();
    mask_q.delete();
  endtask

  initial begin : main
    vec_t                 vecs[10];
    logic [NUM_NOTES-1:0] bp_mask;
    int                   base;
    int                   guard;

    peak_bin   = '0;
    peak_last  = 1'b0;
    peak_valid = 1'b0;
    rst_in     = 1'b1;

    // {bin, last, engine answer, no-answer, expected frame mask}
    vecs[0] = '{13'd131, 1'b0, 6'h21, 1'b0, 22'h000000};
    vecs[1] = '{13'd250, 1'b1, 6'h2C, 1'b0, 22'h001002};
    vecs[2] = '{13'd50,  1'b1, 6'h00, 1'b0, 22'h000000};
    vecs[3] = '{13'd7,   1'b0, 6'h25, 1'b0, 22'h000000};
    vecs[4] = '{13'd8,   1'b0, 6'h25, 1'b0, 22'h000000};
    vecs[5] = '{13'd9,   1'b1, 6'h3E, 1'b0, 22'h000020};
    vecs[6] = '{13'd300, 1'b0, 6'h03, 1'b0, 22'h000000};
    vecs[7] = '{13'd301, 1'b1, 6'h35, 1'b0, 22'h200000};
    vecs[8] = '{13'd400, 1'b0, 6'h20, 1'b0, 22'h000000};
    vecs[9] = '{13'd401, 1'b1, 6'h36, 1'b0, 22'h000001};

    @(negedge clk);
    do_reset();
    @(negedge clk);
    check("rst_peak_ready", 32'(peak_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_lk_start", 32'(lk_start), 32'd0);
    check("rst_lk_bin", 32'(lk_bin), 32'd0);
    check("rst_mask_out", 32'(mask_out), 32'd0);
    check("rst_mask_valid", 32'(mask_valid), 32'd0);
    check("rst_timeout_count", 32'(timeout_count), 32'd0);

    // Table frames: single frame, all-miss, duplicates/out-of-range, boundaries
    base = lk_cnt;
    for (int i = 0; i < 10; i++) begin
      push_peak(vecs[i].bin, vecs[i].last, vecs[i].note, vecs[i].noans, vecs[i].exp_mask);
    end
    drain("table_drain");
    check("table_lk_start_count", 32'(lk_cnt - base), 32'd10);
    check("table_mask_count", 32'(mask_cnt), 32'd5);

    // Backpressure: stalled engine, 9 back-to-back peaks fill the FIFO
    eng_stall = 1'b1;
    base      = lk_cnt;
    bp_mask   = '0;
    for (int i = 0; i < 9; i++) begin
      bp_mask = bp_mask | (22'h1 << (2 * i));
      push_peak(13'(1000 + i), (i == 8), {1'b1, 5'(2 * i)}, 1'b0, bp_mask);
    end
    check("bp_ready_full", 32'(peak_ready), 32'd0);
    check("bp_busy", 32'(busy), 32'd1);
    peak_bin   = 13'd2000;
    peak_last  = 1'b0;
    peak_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("bp_ready_held", 32'(peak_ready), 32'd0);
    peak_valid = 1'b0;
    eng_stall  = 1'b0;
    drain("bp_drain");
    check("bp_lk_start_count", 32'(lk_cnt - base), 32'd9);
    check("bp_ready_after", 32'(peak_ready), 32'd1);

    // Reset while a lookup is outstanding, then a late lk_done
    eng_stall = 1'b1;
    push_peak(13'd77, 1'b1, 6'h23, 1'b0, 22'h000008);
    guard = 0;
    while (lk_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("rmid_lk_start_seen", 32'(guard < 100), 32'd1);
    repeat (2) @(negedge clk);
    check("rmid_busy_before", 32'(busy), 32'd1);
    base   = mask_cnt;
    rst_in = 1'b1;
    @(negedge clk);
    rst_in = 1'b0;
    mask_q.delete();
    eng_stall = 1'b0;
    repeat (6) @(negedge clk);
    check("rmid_busy", 32'(busy), 32'd0);
    check("rmid_no_mask", 32'(mask_cnt - base), 32'd0);
    check("rmid_mask_out", 32'(mask_out), 32'd0);
    check("rmid_lk_start", 32'(lk_start), 32'd0);
    check("rmid_lk_bin", 32'(lk_bin), 32'd0);
    check("rmid_peak_ready", 32'(peak_ready), 32'd1);

    // Recovery frame after the abandoned lookup
    push_peak(13'd60, 1'b1, 6'h2A, 1'b0, 22'h000400);
    drain("recover_drain");

`ifdef NOTE_SEQ_TIMEOUT_EN
    // The middle peak is never answered and must drop out of the mask
    push_peak(13'd500, 1'b0, 6'h22, 1'b0, 22'h000000);
    push_peak(13'd501, 1'b0, 6'h27, 1'b1, 22'h000000);
    push_peak(13'd502, 1'b1, 6'h24, 1'b0, 22'h000014);
    drain("timeout_drain");
    check("timeout_count", 32'(timeout_count), 32'd1);
`else
    check("timeout_count_tied", 32'(timeout_count), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
